gpio_conditioner: RTL and testbench

GPIO_CONDITIONER -- requirements
Module: gpio_conditioner

---
 rtl/gpio_conditioner.sv | 87 ++++++++
 tb/tb_gpio_conditioner.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_conditioner.sv
// Per-channel GPIO conditioning: pad synchronizer, debounce, edge detect,
// sticky interrupt pending flags and output-enable pass-through.
module gpio_conditioner #(
    parameter int GPIO_WIDTH      = 3,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 120000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [GPIO_WIDTH-1:0] gpio_pad_in,
    input  logic [GPIO_WIDTH-1:0] gpio_oe,
    input  logic [GPIO_WIDTH-1:0] gpio_output,
    input  logic [GPIO_WIDTH-1:0] rise_enable,
    input  logic [GPIO_WIDTH-1:0] fall_enable,
    input  logic [GPIO_WIDTH-1:0] pending_clear,
    output logic [GPIO_WIDTH-1:0] gpio_pad_oe,
    output logic [GPIO_WIDTH-1:0] gpio_pad_out,
    output logic [GPIO_WIDTH-1:0] gpio_input,
    output logic [GPIO_WIDTH-1:0] rise_event,
    output logic [GPIO_WIDTH-1:0] fall_event,
    output logic [GPIO_WIDTH-1:0] pending,
    output logic                  irq
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [GPIO_WIDTH-1:0] stable;
    logic [GPIO_WIDTH-1:0] prev;
    logic [GPIO_WIDTH-1:0] pend_q;

    assign gpio_pad_oe  = gpio_oe;
    assign gpio_pad_out = gpio_output;

    genvar g;
    for (g = 0; g < GPIO_WIDTH; g++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic [CW-1:0]          count;
        logic                   stable_q;
        logic                   sync_out;

        assign sync_out  = sync_q[SYNC_STAGES-1];
        assign stable[g] = stable_q;

        always_ff @(posedge clock) begin
            if (reset) begin
                sync_q   <= '0;
                count    <= '0;
                stable_q <= 1'b0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], gpio_pad_in[g]};
                // Loopback: in output mode the driven value is the input.
                if (gpio_oe[g]) begin
                    stable_q <= gpio_output[g];
                    count    <= '0;
                end else if (sync_out == stable_q) begin
                    count <= '0;
                end else if (count == LAST) begin
                    stable_q <= sync_out;
                    count    <= '0;
                end else begin
                    count <= count + 1'b1;
                end
            end
        end
    end

    assign gpio_input = stable;
    assign rise_event = stable & ~prev;
    assign fall_event = ~stable & prev;
    assign pending    = pend_q;
    assign irq        = |pend_q;

    // New events take priority over a coincident clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            prev   <= '0;
            pend_q <= '0;
        end else begin
            prev   <= stable;
            pend_q <= (pend_q & ~pending_clear)
                    | (rise_event & rise_enable)
                    | (fall_event & fall_enable);
        end
    end

endmodule

// File: tb/tb_gpio_conditioner.sv
// Bench for gpio_conditioner: vector table, hand corner-case sequences
// and randomized stimulus against a behavioural model.
module tb_gpio_conditioner;

    localparam int W = 3;
    localparam int S = 2;
    localparam int D = 4;

    logic         clock = 1'b0;
    logic         reset;
    logic [W-1:0] gpio_pad_in, gpio_oe, gpio_output;
    logic [W-1:0] rise_enable, fall_enable, pending_clear;
    logic [W-1:0] gpio_pad_oe, gpio_pad_out, gpio_input;
    logic [W-1:0] rise_event, fall_event, pending;
    logic         irq;

    gpio_conditioner #(
        .GPIO_WIDTH(W),
        .SYNC_STAGES(S),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clock(clock),
        .reset(reset),
        .gpio_pad_in(gpio_pad_in),
        .gpio_oe(gpio_oe),
        .gpio_output(gpio_output),
        .rise_enable(rise_enable),
        .fall_enable(fall_enable),
        .pending_clear(pending_clear),
        .gpio_pad_oe(gpio_pad_oe),
        .gpio_pad_out(gpio_pad_out),
        .gpio_input(gpio_input),
        .rise_event(rise_event),
        .fall_event(fall_event),
        .pending(pending),
        .irq(irq)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    bit [W-1:0] hist[$];
    bit [W-1:0] m_stable, m_prev, m_pend;
    int         m_run[W];

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_stable = '0;
        m_prev   = '0;
        m_pend   = '0;
        for (int c = 0; c < W; c++) m_run[c] = 0;
        hist.delete();
        for (int k = 0; k < S; k++) hist.push_back('0);
    endtask

    // Stable level follows the synchronized pad once it has disagreed
    // for D consecutive cycles; output mode forces it to the driven value.
    task automatic model_edge(input bit [W-1:0] pad, oe, out, ren, fen, clr);
        bit [W-1:0] so, ev, nxt;
        so  = hist[S-1];
        ev  = ((m_stable & ~m_prev) & ren) | ((~m_stable & m_prev) & fen);
        m_pend = ev | (m_pend & ~clr);
        nxt = m_stable;
        for (int c = 0; c < W; c++) begin
            if (oe[c]) begin
                nxt[c] = out[c];
                m_run[c] = 0;
            end else if (so[c] == m_stable[c]) begin
                m_run[c] = 0;
            end else begin
                m_run[c] = m_run[c] + 1;
                if (m_run[c] == D) begin
                    nxt[c] = so[c];
                    m_run[c] = 0;
                end
            end
        end
        m_prev   = m_stable;
        m_stable = nxt;
        hist.push_front(pad);
        void'(hist.pop_back());
    endtask

    task automatic cycle(input bit rst, input bit [W-1:0] pad, oe, out,
                         input bit [W-1:0] ren, fen, clr);
        logic [6*W:0] got, exp;
        reset = rst;
        gpio_pad_in = pad;
        gpio_oe = oe;
        gpio_output = out;
        rise_enable = ren;
        fall_enable = fen;
        pending_clear = clr;
        @(posedge clock);
        if (rst) model_reset();
        else model_edge(pad, oe, out, ren, fen, clr);
        #1;
        got = {gpio_pad_oe, gpio_pad_out, gpio_input, rise_event,
               fall_event, pending, irq};
        exp = {oe, out, m_stable, m_stable & ~m_prev,
               ~m_stable & m_prev, m_pend, |m_pend};
        chk("model", 32'(got), 32'(exp));
    endtask

    typedef struct {
        bit       rst;
        bit [W-1:0] pad, oe, out, ren, fen, clr;
        bit [W-1:0] gin, rise, fall, pend;
    } vec_t;

    vec_t tbl[13];

    initial begin
        model_reset();
        reset = 1'b1;
        gpio_pad_in = '0;
        gpio_oe = '0;
        gpio_output = '0;
        rise_enable = '0;
        fall_enable = '0;
        pending_clear = '0;

        // Debounced rise on ch0, pending/clear, then loopback on ch2
        tbl[0] = '{1'b1, 3'b000, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000,
                   3'b000, 3'b000, 3'b000, 3'b000};
        for (int r = 1; r <= 5; r++)
            tbl[r] = '{1'b0, 3'b001, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000,
                       3'b000, 3'b000, 3'b000, 3'b000};
        tbl[6] = '{1'b0, 3'b001, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000,
                   3'b001, 3'b001, 3'b000, 3'b000};
        tbl[7] = '{1'b0, 3'b001, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000,
                   3'b001, 3'b000, 3'b000, 3'b001};
        tbl[8] = '{1'b0, 3'b001, 3'b000, 3'b000, 3'b001, 3'b000, 3'b001,
                   3'b001, 3'b000, 3'b000, 3'b000};
        tbl[9] = '{1'b0, 3'b001, 3'b100, 3'b100, 3'b001, 3'b000, 3'b000,
                   3'b101, 3'b100, 3'b000, 3'b000};
        tbl[10] = '{1'b0, 3'b101, 3'b100, 3'b100, 3'b001, 3'b000, 3'b000,
                    3'b101, 3'b000, 3'b000, 3'b000};
        tbl[11] = '{1'b0, 3'b101, 3'b100, 3'b000, 3'b001, 3'b000, 3'b000,
                    3'b001, 3'b000, 3'b100, 3'b000};
        tbl[12] = '{1'b0, 3'b001, 3'b100, 3'b000, 3'b001, 3'b000, 3'b000,
                    3'b001, 3'b000, 3'b000, 3'b000};

        for (int r = 0; r < 13; r++) begin
            cycle(tbl[r].rst, tbl[r].pad, tbl[r].oe, tbl[r].out,
                  tbl[r].ren, tbl[r].fen, tbl[r].clr);
            chk($sformatf("table[%0d]", r),
                32'({gpio_input, rise_event, fall_event, pending, irq,
                     gpio_pad_oe, gpio_pad_out}),
                32'({tbl[r].gin, tbl[r].rise, tbl[r].fall, tbl[r].pend,
                     |tbl[r].pend, tbl[r].oe, tbl[r].out}));
        end

        // Short glitch on ch0 must be rejected
        cycle(1'b1, 3'b000, 3'b000, 3'b000, 3'b001, 3'b001, 3'b000);
        for (int k = 0; k < 3; k++)
            cycle(1'b0, 3'b001, 3'b000, 3'b000, 3'b001, 3'b001, 3'b000);
        for (int k = 0; k < 8; k++) begin
            cycle(1'b0, 3'b000, 3'b000, 3'b000, 3'b001, 3'b001, 3'b000);
            chk("glitch", 32'({gpio_input, rise_event, fall_event, pending}),
                32'd0);
        end

        // Pending on ch1: set, clear, then set wins over coincident clear
        cycle(1'b1, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
        for (int k = 0; k < 6; k++)
            cycle(1'b0, 3'b010, 3'b000, 3'b000, 3'b010, 3'b010, 3'b000);
        chk("rise1", 32'({gpio_input, rise_event}), 32'({3'b010, 3'b010}));
        cycle(1'b0, 3'b010, 3'b000, 3'b000, 3'b010, 3'b010, 3'b000);
        chk("pend1", 32'({pending, irq}), 32'({3'b010, 1'b1}));
        cycle(1'b0, 3'b010, 3'b000, 3'b000, 3'b010, 3'b010, 3'b010);
        chk("clear1", 32'({pending, irq}), 32'({3'b000, 1'b0}));
        cycle(1'b0, 3'b010, 3'b000, 3'b000, 3'b010, 3'b010, 3'b000);
        for (int k = 0; k < 6; k++)
            cycle(1'b0, 3'b000, 3'b000, 3'b000, 3'b010, 3'b010, 3'b000);
        chk("fall1", 32'({gpio_input, fall_event}), 32'({3'b000, 3'b010}));
        cycle(1'b0, 3'b000, 3'b000, 3'b000, 3'b010, 3'b010, 3'b010);
        chk("set_wins", 32'({pending, irq}), 32'({3'b010, 1'b1}));
        cycle(1'b0, 3'b000, 3'b000, 3'b000, 3'b010, 3'b010, 3'b010);
        chk("clear2", 32'({pending, irq}), 32'({3'b000, 1'b0}));

        // Reset mid-count, pad held high through release
        cycle(1'b1, 3'b000, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000);
        for (int k = 0; k < 3; k++)
            cycle(1'b0, 3'b001, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000);
        cycle(1'b1, 3'b001, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000);
        chk("in_reset", 32'({gpio_input, rise_event, fall_event, pending, irq}),
            32'd0);
        for (int k = 0; k < 6; k++) begin
            cycle(1'b0, 3'b001, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000);
            if (k < 5) chk("post_rst_low", 32'(gpio_input), 32'd0);
        end
        chk("post_rst_rise", 32'({gpio_input, rise_event}),
            32'({3'b001, 3'b001}));

        // Randomized run against the model
        begin
            bit [W-1:0] pad, oe, out;
            pad = '0;
            oe  = '0;
            out = '0;
            for (int n = 0; n < 4000; n++) begin
                for (int c = 0; c < W; c++) begin
                    if ($urandom_range(0, 5) == 0) pad[c] = ~pad[c];
                    if ($urandom_range(0, 39) == 0) oe[c] = ~oe[c];
                    if ($urandom_range(0, 4) == 0) out[c] = ~out[c];
                end
                cycle($urandom_range(0, 499) == 0, pad, oe, out,
                      W'($urandom), W'($urandom),
                      W'($urandom) & W'($urandom));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
